// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target front end.
//   i2c_state_e  : byte-level protocol FSM states
//   i2c_line_t   : conditioned pad line (filtered level + edge strobes)
//   I2C_RW_*     : R/W bit encoding of the address byte
//   UNDERRUN_BYTE: byte sent when the decoder has nothing ready
package i2c_target_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned BITCNT_W = 3;

   localparam logic I2C_RW_READ  = 1'b1;
   localparam logic I2C_RW_WRITE = 1'b0;

   localparam logic [BYTE_W-1:0] UNDERRUN_BYTE = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_LOAD,
      RD_BYTE,
      RD_ACK
   } i2c_state_e;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } i2c_line_t;

   // True when the upper seven bits of an address byte select this target.
   function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                       input logic [ADDR_W-1:0] own_addr);
      return addr_byte[BYTE_W-1:1] == own_addr;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one open-drain I2C pad: 2-FF synchroniser followed by a
// glitch filter that accepts a new level only after FILTER_LEN consecutive
// equal synchronised samples. Total pad-to-level latency is 2+FILTER_LEN
// cycles. Level resets to 1 (idle bus).
//   clk, reset : system clock, synchronous active-high reset
//   pad        : raw pad input
//   line       : filtered level plus 1-cycle rise/fall strobes (aligned
//                with the level change)
// FILTER_LEN must be at least 2.
module i2c_line_filter
   import i2c_target_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      pad,
   output i2c_line_t line
);

   localparam int unsigned HIST_W = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;

   logic [1:0]        sync;
   logic [HIST_W-1:0] hist;
   logic              all_hi;
   logic              all_lo;

   // The newest synchronised sample plus HIST_W older ones form the window.
   always_comb begin
      all_hi = sync[1] & (&hist);
      all_lo = ~sync[1] & ~(|hist);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync       <= '1;
         hist       <= '1;
         line.level <= 1'b1;
         line.rise  <= 1'b0;
         line.fall  <= 1'b0;
      end else begin
         sync    <= {sync[0], pad};
         hist[0] <= sync[1];
         for (int i = 1; i < int'(HIST_W); i++) begin
            hist[i] <= hist[i-1];
         end
         line.rise <= 1'b0;
         line.fall <= 1'b0;
         if (all_hi && !line.level) begin
            line.level <= 1'b1;
            line.rise  <= 1'b1;
         end else if (all_lo && line.level) begin
            line.level <= 1'b0;
            line.fall  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_target_phy.sv
// Byte-level I2C target front end for the bootloader command path.
// Receives host writes to I2C_ADDRESS as an rx byte stream with START/STOP
// strobes, and serialises decoder bytes for host reads through a one-byte
// transmit holding register.
//   clk, reset            : 12 MHz system clock, synchronous active-high reset
//   i2c_scl_in/sda_in     : pad inputs
//   i2c_sda_oe/scl_oe     : 1 = pull line low (open drain)
//   rx_data/rx_valid      : received write byte + 1-cycle strobe
//   tx_req                : 1-cycle request for the next read byte
//   tx_data/tx_valid      : read byte from the decoder
//   tx_underrun           : no byte ready when one had to be sent
//   start_det/stop_det    : bus START (incl. repeated) / STOP strobes
//   selected/is_read      : addressed transaction active / its R/W bit
// Build option I2C_CLOCK_STRETCH_EN: hold SCL low while the holding register
// is empty at byte load time instead of sending UNDERRUN_BYTE; otherwise
// i2c_scl_oe stays 0.
module i2c_target_phy
   import i2c_target_pkg::*;
#(
   parameter logic [ADDR_W-1:0] I2C_ADDRESS = 7'h2F,
   parameter int unsigned       FILTER_LEN  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i2c_scl_in,
   input  logic              i2c_sda_in,
   output logic              i2c_sda_oe,
   output logic              i2c_scl_oe,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_req,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_underrun,
   output logic              start_det,
   output logic              stop_det,
   output logic              selected,
   output logic              is_read
);

   i2c_line_t scl;
   i2c_line_t sda;

   i2c_state_e state_q, state_d;
   logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [BYTE_W-2:0]   shreg_q, shreg_d;
   logic [BYTE_W-2:0]   txsh_q, txsh_d;
   logic [BYTE_W-1:0]   hold_q, hold_d;
   logic                hold_full_q, hold_full_d;
   logic                mack_q, mack_d;
   logic                sda_oe_q, sda_oe_d;
   logic                scl_oe_q, scl_oe_d;
   logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                tx_req_q, tx_req_d;
   logic                tx_underrun_q, tx_underrun_d;
   logic                start_det_q, start_det_d;
   logic                stop_det_q, stop_det_d;
   logic                selected_q, selected_d;
   logic                is_read_q, is_read_d;

   logic                start_c;
   logic                stop_c;
   logic                scl_rise_c;
   logic                scl_fall_c;
   logic                load_c;
   logic [BYTE_W-1:0]   shift_in_c;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk   (clk),
      .reset (reset),
      .pad   (i2c_scl_in),
      .line  (scl)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk   (clk),
      .reset (reset),
      .pad   (i2c_sda_in),
      .line  (sda)
   );

   // Bus events and SCL edges derived from the filtered lines.
   always_comb begin
      start_c    = sda.fall & scl.level;
      stop_c     = sda.rise & scl.level;
      scl_rise_c = scl.rise;
`ifdef I2C_CLOCK_STRETCH_EN
      // A fall seen while we hold SCL ourselves is not the host's clock.
      scl_fall_c = scl.fall & ~scl_oe_q;
`else
      scl_fall_c = scl.fall;
`endif
      shift_in_c = {shreg_q, sda.level};
   end

   // Next-state and next-output logic; bus events override any byte state.
   always_comb begin
      state_d       = state_q;
      bitcnt_d      = bitcnt_q;
      shreg_d       = shreg_q;
      txsh_d        = txsh_q;
      mack_d        = mack_q;
      sda_oe_d      = sda_oe_q;
      scl_oe_d      = 1'b0;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_req_d      = 1'b0;
      tx_underrun_d = 1'b0;
      start_det_d   = 1'b0;
      stop_det_d    = 1'b0;
      selected_d    = selected_q;
      is_read_d     = is_read_q;
      load_c        = 1'b0;

      if (start_c) begin
         start_det_d = 1'b1;
         state_d     = ADDR;
         bitcnt_d    = '0;
         sda_oe_d    = 1'b0;
         selected_d  = 1'b0;
         mack_d      = 1'b0;
      end else if (stop_c) begin
         stop_det_d = 1'b1;
         state_d    = IDLE;
         sda_oe_d   = 1'b0;
         selected_d = 1'b0;
         mack_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
            end

            ADDR: begin
               if (scl_rise_c) begin
                  shreg_d  = shift_in_c[BYTE_W-2:0];
                  bitcnt_d = bitcnt_q + BITCNT_W'(1);
                  if (bitcnt_q == BITCNT_W'(7)) begin
                     if (addr_match(shift_in_c, I2C_ADDRESS)) begin
                        is_read_d = shift_in_c[0];
                        state_d   = ADDR_ACK;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end

            // First fall drives ACK, second fall releases it.
            ADDR_ACK: begin
               if (scl_fall_c) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                     tx_req_d = (is_read_q == I2C_RW_READ);
                  end else begin
                     sda_oe_d   = 1'b0;
                     selected_d = 1'b1;
                     bitcnt_d   = '0;
                     state_d    = (is_read_q == I2C_RW_READ) ? RD_LOAD : WR_BYTE;
                  end
               end
            end

            WR_BYTE: begin
               if (scl_rise_c) begin
                  shreg_d  = shift_in_c[BYTE_W-2:0];
                  bitcnt_d = bitcnt_q + BITCNT_W'(1);
                  if (bitcnt_q == BITCNT_W'(7)) begin
                     rx_data_d  = shift_in_c;
                     rx_valid_d = 1'b1;
                     state_d    = WR_ACK;
                  end
               end
            end

            WR_ACK: begin
               if (scl_fall_c) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = '0;
                     state_d  = WR_BYTE;
                  end
               end
            end

            RD_LOAD: begin
               if (hold_full_q) begin
                  load_c   = 1'b1;
                  txsh_d   = hold_q[BYTE_W-2:0];
                  sda_oe_d = ~hold_q[BYTE_W-1];
                  bitcnt_d = '0;
                  state_d  = RD_BYTE;
               end else begin
`ifdef I2C_CLOCK_STRETCH_EN
                  scl_oe_d = 1'b1;
`else
                  txsh_d        = UNDERRUN_BYTE[BYTE_W-2:0];
                  sda_oe_d      = ~UNDERRUN_BYTE[BYTE_W-1];
                  tx_underrun_d = 1'b1;
                  bitcnt_d      = '0;
                  state_d       = RD_BYTE;
`endif
               end
            end

            // Bit 7 is already on the line; each fall presents the next bit.
            RD_BYTE: begin
               if (scl_fall_c) begin
                  if (bitcnt_q == BITCNT_W'(7)) begin
                     sda_oe_d = 1'b0;
                     mack_d   = 1'b0;
                     state_d  = RD_ACK;
                  end else begin
                     sda_oe_d = ~txsh_q[BYTE_W-2];
                     txsh_d   = {txsh_q[BYTE_W-3:0], 1'b0};
                     bitcnt_d = bitcnt_q + BITCNT_W'(1);
                  end
               end
            end

            RD_ACK: begin
               if (scl_rise_c) begin
                  if (!sda.level) begin
                     mack_d   = 1'b1;
                     tx_req_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (scl_fall_c && mack_q) begin
                  mack_d  = 1'b0;
                  state_d = RD_LOAD;
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // Transmit holding register: a byte offered on the load cycle is kept for
   // the next load; START/STOP discard any pending byte.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (load_c) begin
         hold_full_d = 1'b0;
      end
      if (tx_valid && !hold_full_d) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
      if (start_c || stop_c) begin
         hold_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         bitcnt_q      <= '0;
         shreg_q       <= '0;
         txsh_q        <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         mack_q        <= 1'b0;
         sda_oe_q      <= 1'b0;
         scl_oe_q      <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         tx_req_q      <= 1'b0;
         tx_underrun_q <= 1'b0;
         start_det_q   <= 1'b0;
         stop_det_q    <= 1'b0;
         selected_q    <= 1'b0;
         is_read_q     <= I2C_RW_WRITE;
      end else begin
         state_q       <= state_d;
         bitcnt_q      <= bitcnt_d;
         shreg_q       <= shreg_d;
         txsh_q        <= txsh_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         mack_q        <= mack_d;
         sda_oe_q      <= sda_oe_d;
         scl_oe_q      <= scl_oe_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_req_q      <= tx_req_d;
         tx_underrun_q <= tx_underrun_d;
         start_det_q   <= start_det_d;
         stop_det_q    <= stop_det_d;
         selected_q    <= selected_d;
         is_read_q     <= is_read_d;
      end
   end

   assign i2c_sda_oe  = sda_oe_q;
   assign i2c_scl_oe  = scl_oe_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_req      = tx_req_q;
   assign tx_underrun = tx_underrun_q;
   assign start_det   = start_det_q;
   assign stop_det    = stop_det_q;
   assign selected    = selected_q;
   assign is_read     = is_read_q;

endmodule

// File: tb/tb_i2c_target_phy.sv
// Directed bench for i2c_target_phy: a bit-level bus master with open-drain
// line model, a decoder model answering tx_req from a byte queue, and
// event monitors. Honours I2C_CLOCK_STRETCH_EN for the underrun case.
module tb_i2c_target_phy;

   localparam int unsigned Q = 10;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       scl_line;
   logic       sda_line;
   logic       i2c_sda_oe;
   logic       i2c_scl_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_underrun;
   logic       start_det;
   logic       stop_det;
   logic       selected;
   logic       is_read;

   always #5 clk = ~clk;

   assign scl_line = scl_m & ~i2c_scl_oe;
   assign sda_line = sda_m & ~i2c_sda_oe;

   i2c_target_phy dut (
      .clk         (clk),
      .reset       (reset),
      .i2c_scl_in  (scl_line),
      .i2c_sda_in  (sda_line),
      .i2c_sda_oe  (i2c_sda_oe),
      .i2c_scl_oe  (i2c_scl_oe),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_req      (tx_req),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_underrun (tx_underrun),
      .start_det   (start_det),
      .stop_det    (stop_det),
      .selected    (selected),
      .is_read     (is_read)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Event monitors
   logic [7:0] rx_log[$];
   int n_txreq = 0, n_under = 0, n_start = 0, n_stop = 0;
   int n_sda_drv = 0, n_stretch = 0;

   always @(negedge clk) begin
      if (rx_valid)    rx_log.push_back(rx_data);
      if (tx_req)      n_txreq++;
      if (tx_underrun) n_under++;
      if (start_det)   n_start++;
      if (stop_det)    n_stop++;
      if (i2c_sda_oe)  n_sda_drv++;
      if (i2c_scl_oe)  n_stretch++;
   end

   function automatic int rx_at(input int i);
      return (i < rx_log.size()) ? int'(rx_log[i]) : -1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Decoder model
   logic [7:0] resp_q[$];
   int resp_delay = 2;

   initial begin
      forever begin
         @(negedge clk);
         if (tx_req === 1'b1 && resp_q.size() > 0) begin
            cyc(resp_delay);
            tx_data  = resp_q.pop_front();
            tx_valid = 1'b1;
            cyc(1);
            tx_valid = 1'b0;
         end
      end
   end

   // Bus master
   task automatic scl_rel();
      int t;
      t = 0;
      scl_m = 1'b1;
      while (scl_line !== 1'b1 && t < 3000) begin
         cyc(1);
         t++;
      end
      if (scl_line !== 1'b1) check("scl_release", int'(scl_line), 1);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; cyc(Q);
      scl_rel();    cyc(Q);
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; cyc(Q);
      scl_rel();    cyc(Q);
      sda_m = 1'b1; cyc(Q);
   endtask

   task automatic put_bit(input logic b);
      sda_m = b; cyc(Q);
      scl_rel(); cyc(2 * Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; cyc(Q);
      scl_rel();    cyc(Q);
      b = sda_line; cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic put_byte(input logic [7:0] v, output int acked);
      logic a;
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
      get_bit(a);
      acked = (a == 1'b0) ? 1 : 0;
   endtask

   task automatic get_byte(output logic [7:0] v, input logic ack);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         get_bit(b);
         v = {v[6:0], b};
      end
      put_bit(~ack);
   endtask

   logic [7:0] wr_bytes[7] = '{8'h01, 8'h02, 8'h00, 8'h05, 8'h00, 8'h9F, 8'h00};

   initial begin
      int a, a2, acks, rb, tb, sb, pb, db, ub, hb;
      logic [7:0] v0, v1, v2;

      // Reset
      cyc(4);
      check("rst_sda_oe", int'(i2c_sda_oe), 0);
      check("rst_scl_oe", int'(i2c_scl_oe), 0);
      check("rst_strobes", int'({rx_valid, tx_req, tx_underrun, start_det, stop_det}), 0);
      check("rst_sel_rd", int'({selected, is_read}), 0);
      check("rst_rx_data", int'(rx_data), 0);
      reset = 1'b0;
      cyc(2 * Q);

      // Write transaction
      rb = rx_log.size(); sb = n_start; pb = n_stop;
      bus_start();
      put_byte(8'h5E, a);
      acks = a;
      check("wr_selected", int'(selected), 1);
      for (int i = 0; i < 7; i++) begin
         put_byte(wr_bytes[i], a);
         acks += a;
      end
      bus_stop();
      cyc(Q);
      check("wr_acks", acks, 8);
      check("wr_rx_count", rx_log.size() - rb, 7);
      for (int i = 0; i < 7; i++) check($sformatf("wr_byte%0d", i), rx_at(rb + i), int'(wr_bytes[i]));
      check("wr_start", n_start - sb, 1);
      check("wr_stop", n_stop - pb, 1);
      check("wr_is_read", int'(is_read), 0);
      check("wr_sel_after_stop", int'(selected), 0);

      // Wrong address
      rb = rx_log.size(); db = n_sda_drv;
      bus_start();
      put_byte(8'h60, a);
      check("wa_selected", int'(selected), 0);
      put_byte(8'h01, a2);
      bus_stop();
      cyc(Q);
      check("wa_addr_ack", a, 0);
      check("wa_data_ack", a2, 0);
      check("wa_sda_driven", n_sda_drv - db, 0);
      check("wa_rx_count", rx_log.size() - rb, 0);

      // Read transaction
      tb = n_txreq; ub = n_under;
      resp_q.push_back(8'hEF); resp_q.push_back(8'h40); resp_q.push_back(8'h16);
      bus_start();
      put_byte(8'h5F, a);
      check("rd_addr_ack", a, 1);
      check("rd_is_read", int'(is_read), 1);
      get_byte(v0, 1'b1);
      get_byte(v1, 1'b1);
      get_byte(v2, 1'b0);
      cyc(2);
      check("rd_sda_released", int'(i2c_sda_oe), 0);
      bus_stop();
      cyc(Q);
      check("rd_byte0", int'(v0), 'hEF);
      check("rd_byte1", int'(v1), 'h40);
      check("rd_byte2", int'(v2), 'h16);
      check("rd_tx_req", n_txreq - tb, 3);
      check("rd_underrun", n_under - ub, 0);

      // Underrun
      ub = n_under; hb = n_stretch;
`ifdef I2C_CLOCK_STRETCH_EN
      resp_delay = 500;
      resp_q.push_back(8'hA5);
`endif
      bus_start();
      put_byte(8'h5F, a);
      get_byte(v0, 1'b0);
      bus_stop();
      cyc(Q);
      resp_delay = 2;
`ifdef I2C_CLOCK_STRETCH_EN
      check("ur_byte", int'(v0), 'hA5);
      check("ur_underrun", n_under - ub, 0);
      check("ur_stretched", int'((n_stretch - hb) > 400), 1);
`else
      check("ur_byte", int'(v0), 'hFF);
      check("ur_underrun", n_under - ub, 1);
      check("ur_scl_oe", n_stretch - hb, 0);
`endif

      // Repeated START inside a write byte
      rb = rx_log.size(); sb = n_start;
      bus_start();
      put_byte(8'h5E, a);
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
      bus_start();
      check("rs_sel_cleared", int'(selected), 0);
      put_byte(8'h5E, a2);
      check("rs_addr_ack", a2, 1);
      put_byte(8'h77, a);
      check("rs_selected", int'(selected), 1);
      bus_stop();
      cyc(Q);
      check("rs_rx_count", rx_log.size() - rb, 1);
      check("rs_rx_byte", rx_at(rb), 'h77);
      check("rs_start", n_start - sb, 2);

      // Reset while driving a 0 bit during a read
      resp_q.push_back(8'h00);
      bus_start();
      put_byte(8'h5F, a);
      cyc(2);
      check("rr_driving", int'(i2c_sda_oe), 1);
      reset = 1'b1;
      cyc(1);
      check("rr_sda_released", int'(i2c_sda_oe), 0);
      reset = 1'b0;
      cyc(1);
      check("rr_selected", int'(selected), 0);
      cyc(2 * Q);
      bus_stop();
      cyc(Q);
      rb = rx_log.size();
      bus_start();
      put_byte(8'h5E, a);
      put_byte(8'h3C, a2);
      bus_stop();
      cyc(Q);
      check("rr_addr_ack", a, 1);
      check("rr_rx_byte", rx_at(rb), 'h3C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_target_phy.md
Name: i2c_target_phy

Overview:
- Byte-level I2C target (slave) front end of the bootloader's I2C command path.
- Sits between the `i2c_sda`/`i2c_scl` pads and the command/SPI-bridge decoder.
- Receive side: converts host write transactions at address 0x2F into a byte stream with start/stop framing strobes.
- Transmit side: serialises decoder-supplied bytes for host read transactions.

Parameters:
- I2C_ADDRESS, 7'h2F, 7-bit target address matched after START.
- FILTER_LEN, 3, consecutive equal synchronised samples needed to accept a new SCL/SDA level.

Ports:
- clk  in  1  system clock (12 MHz nominal)
- reset  in  1  synchronous, active-high reset
- i2c_scl_in  in  1  SCL pad input
- i2c_sda_in  in  1  SDA pad input
- i2c_sda_oe  out  1  1 = pull SDA low (open-drain)
- i2c_scl_oe  out  1  1 = pull SCL low; tied 0 unless I2C_CLOCK_STRETCH_EN
- rx_data  out  8  received write byte
- rx_valid  out  1  1-cycle strobe, rx_data valid
- tx_req  out  1  1-cycle strobe, next read byte wanted
- tx_data  in  8  read byte from decoder
- tx_valid  in  1  tx_data valid; sampled any cycle after tx_req until load
- tx_underrun  out  1  1-cycle strobe, no byte available at load time
- start_det  out  1  1-cycle strobe on START or repeated START
- stop_det  out  1  1-cycle strobe on STOP
- selected  out  1  high from address ACK until STOP/START/NACKed address
- is_read  out  1  R/W bit of current selected transaction

Behaviour:
- Reset values: all outputs 0; state IDLE; filters preset to 1 (bus idle); tx holding register empty.

Line conditioning:
- SCL/SDA pass 2-FF synchroniser, then FILTER_LEN filter.
- Edge strobes come from filtered levels.
- Total input latency is 2+FILTER_LEN cycles.

Bus events:
- START: SDA fall while SCL high, in any state.
  - Effects: start_det, state ADDR, bitcnt=0, sda_oe=0, selected=0.
- STOP: SDA rise while SCL high.
  - Effects: stop_det, state IDLE, sda_oe=0, selected=0.
- START/STOP take priority over any in-progress byte; a partial byte is discarded and no rx_valid is issued.
- Data sampling: target samples SDA on filtered SCL rise.
- Data driving: target changes sda_oe in the cycle after filtered SCL fall.

States:
- IDLE: ignore everything except START.
- ADDR: shift 8 bits, MSB first.
  - After 8th rise, if addr[7:1]==I2C_ADDRESS: latch is_read, go ADDR_ACK.
  - Otherwise go IDLE without ACK.
- ADDR_ACK:
  - On SCL fall: sda_oe=1.
  - If is_read, pulse tx_req on that same fall.
  - On next fall: sda_oe=0 and selected=1.
  - Then go WR_BYTE, or RD_LOAD if is_read.
- WR_BYTE: shift 8 bits.
  - On 8th rise: rx_data=byte, rx_valid pulse (the cycle after the rise is detected).
  - Then go WR_ACK.
- WR_ACK:
  - On fall: sda_oe=1. On next fall: sda_oe=0, go WR_BYTE.
  - Always ACK; there is no receive backpressure.
- RD_LOAD:
  - If holding register full: load shifter, clear holding register.
  - If empty: load 8'hFF and pulse tx_underrun.
  - Then go RD_BYTE.
- RD_BYTE:
  - Drive bit 7 immediately; shift on each fall.
  - sda_oe = ~bit; a 1 bit is released, never driven high.
  - After 8th fall, sda_oe=0 and go RD_ACK.
- RD_ACK: sample master ACK on rise.
  - ACK (SDA=0): pulse tx_req, go RD_LOAD on next fall.
  - NACK: go IDLE; sda_oe stays 0.

Transmit holding register:
- One byte; captures tx_data when tx_valid and the register is empty.
- Extra tx_valid while full is ignored.
- Cleared on START, STOP and reset.

Boundary conditions:
- Reset mid-transfer releases SDA in the next cycle.
- General-call address 0x00 is not matched.
- tx_valid in the same cycle as a load is captured for the next byte, not the current one.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined:
  - In RD_LOAD with holding register empty, assert i2c_scl_oe, holding SCL low instead of sending 0xFF.
  - Release SCL the cycle after tx_valid captures a byte; that byte is then loaded.
  - No underrun occurs; tx_underrun stays 0.
  - Filtered SCL edges caused by the target's own stretching are ignored.
- Undefined: i2c_scl_oe is constant 0; the 0xFF underrun behaviour above applies.

Decomposition:
- Package i2c_target_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK)
  - I2C_RW_READ=1, I2C_RW_WRITE=0
  - UNDERRUN_BYTE=8'hFF
- Sub-module i2c_line_filter: synchroniser + FILTER_LEN filter + rise/fall strobes.
  - Instantiated once for SCL and once for SDA.

Test Plan:
- Write: START, 0x5E, bytes 01 02 00 05 00 9F 00, STOP.
  - Expect: 8 ACKs; 7 rx_valid with exactly those values; start_det=1, stop_det=1; is_read=0.
- Wrong address: START, 0x60 (addr 0x30), 0x01.
  - Expect: SDA never driven; no rx_valid; selected=0.
- Read: START, 0x5F; decoder answers tx_req with EF, 40, 16; master ACK, ACK, NACK; STOP.
  - Expect: SDA bit streams EF/40/16 MSB-first; 3 tx_req; SDA released after NACK.
- Underrun:
  - Without macro: read with no tx_valid gives 0xFF on the bus and one tx_underrun pulse.
  - With macro: SCL is held low until tx_valid=1 with 0xA5 arrives 500 cycles later, then 0xA5 is sent.
- Repeated START after 3 bits of a write byte: no rx_valid, start_det pulses, new address accepted.
- Reset mid-read while driving a 0 bit: sda_oe=0 next cycle; state IDLE; the following transaction works normally.
